// File: rtl/ctrl_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_rst_seq
// Purpose  : Reset sequencer. Waits for a stable clock-generator lock,
//            releases the SDRAM controller reset, waits for SDRAM init,
//            then releases the CPU/chipset reset. Loss of lock at any point
//            re-asserts every reset and restarts the sequence.
// Ports    : clk             - system clock, rising edge
//            rst             - synchronous active-high reset
//            pll_locked      - asynchronous lock flag (synchronized here)
//            sdram_init_done - SDRAM controller init-complete level
//            sw_rst_req      - single-cycle soft reset (CPU only, RUN only)
//            rst_sdram       - SDRAM controller reset, active high
//            rst_cpu         - CPU/chipset reset, active high
//            rst_ready       - high only while in RUN
//            init_err        - sticky SDRAM init timeout flag
//            lock_loss_cnt   - saturating count of lock losses
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_rst_seq #(
   parameter int LOCK_STABLE = 1024,
   parameter int INIT_TMO    = 65535,
   parameter int CPU_DLY     = 256,
   parameter int CW          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       sdram_init_done,
   input  logic       sw_rst_req,
   output logic       rst_sdram,
   output logic       rst_cpu,
   output logic       rst_ready,
   output logic       init_err,
   output logic [7:0] lock_loss_cnt
);

   typedef enum logic [2:0] {
      S_WAIT_LOCK  = 3'd0,
      S_STABLE     = 3'd1,
      S_SDRAM_INIT = 3'd2,
      S_CPU_DLY    = 3'd3,
      S_RUN        = 3'd4
   } state_t;

   // Terminal counts: the counter is cleared on every state entry, so a
   // wait of N cycles ends when it reads N-1.
   localparam logic [CW-1:0] c_ls_term  = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] c_tmo_term = CW'(INIT_TMO - 1);
   localparam logic [CW-1:0] c_cpu_term = CW'(CPU_DLY - 1);
   localparam logic [CW-1:0] c_cnt_one  = CW'(1);

   state_t        r_state;
   state_t        w_state_nx;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nx;
   logic          r_sync1;
   logic          r_sync2;
   logic          w_locked_s;
   logic          w_rst_sdram_nx;
   logic          w_rst_cpu_nx;
   logic          w_rst_ready_nx;
   logic          w_init_err_nx;
   logic [7:0]    w_lock_loss_cnt_nx;

   assign w_locked_s = r_sync2;

   // 2-FF synchronizer; the only consumer of pll_locked.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // State, counter and all outputs are registered so every output changes
   // on the same edge as the transition that causes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_WAIT_LOCK;
         r_cnt         <= '0;
         rst_sdram     <= 1'b1;
         rst_cpu       <= 1'b1;
         rst_ready     <= 1'b0;
         init_err      <= 1'b0;
         lock_loss_cnt <= 8'd0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         rst_sdram     <= w_rst_sdram_nx;
         rst_cpu       <= w_rst_cpu_nx;
         rst_ready     <= w_rst_ready_nx;
         init_err      <= w_init_err_nx;
         lock_loss_cnt <= w_lock_loss_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx         = r_state;
      w_cnt_nx           = r_cnt;
      w_rst_sdram_nx     = rst_sdram;
      w_rst_cpu_nx       = rst_cpu;
      w_rst_ready_nx     = rst_ready;
      w_init_err_nx      = init_err;
      w_lock_loss_cnt_nx = lock_loss_cnt;

      // Lock loss outranks timeout, terminal counts and soft reset.
      if ((r_state != S_WAIT_LOCK) && !w_locked_s) begin
         w_state_nx     = S_WAIT_LOCK;
         w_cnt_nx       = '0;
         w_rst_sdram_nx = 1'b1;
         w_rst_cpu_nx   = 1'b1;
         w_rst_ready_nx = 1'b0;
         if (lock_loss_cnt != 8'hFF) begin
            w_lock_loss_cnt_nx = lock_loss_cnt + 8'd1;
         end
      end else begin
         case (r_state)
            S_WAIT_LOCK: begin
               w_rst_sdram_nx = 1'b1;
               w_rst_cpu_nx   = 1'b1;
               w_rst_ready_nx = 1'b0;
               if (w_locked_s) begin
                  w_state_nx = S_STABLE;
                  w_cnt_nx   = '0;
               end
            end
            S_STABLE: begin
               if (r_cnt == c_ls_term) begin
                  w_state_nx     = S_SDRAM_INIT;
                  w_cnt_nx       = '0;
                  w_rst_sdram_nx = 1'b0;
               end else begin
                  w_cnt_nx = r_cnt + c_cnt_one;
               end
            end
            S_SDRAM_INIT: begin
               if (sdram_init_done) begin
                  w_state_nx = S_CPU_DLY;
                  w_cnt_nx   = '0;
               end else if (r_cnt == c_tmo_term) begin
                  // Retry: put the SDRAM controller back in reset and
                  // re-run the lock-stable wait before releasing again.
                  w_state_nx     = S_STABLE;
                  w_cnt_nx       = '0;
                  w_init_err_nx  = 1'b1;
                  w_rst_sdram_nx = 1'b1;
               end else begin
                  w_cnt_nx = r_cnt + c_cnt_one;
               end
            end
            S_CPU_DLY: begin
               if (r_cnt == c_cpu_term) begin
                  w_state_nx     = S_RUN;
                  w_cnt_nx       = '0;
                  w_rst_cpu_nx   = 1'b0;
                  w_rst_ready_nx = 1'b1;
               end else begin
                  w_cnt_nx = r_cnt + c_cnt_one;
               end
            end
            S_RUN: begin
               // Soft reset touches only the CPU side; SDRAM stays out of reset.
               if (sw_rst_req) begin
                  w_state_nx     = S_CPU_DLY;
                  w_cnt_nx       = '0;
                  w_rst_cpu_nx   = 1'b1;
                  w_rst_ready_nx = 1'b0;
               end
            end
            default: begin
               w_state_nx     = S_WAIT_LOCK;
               w_cnt_nx       = '0;
               w_rst_sdram_nx = 1'b1;
               w_rst_cpu_nx   = 1'b1;
               w_rst_ready_nx = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
